conv_encoder_tx: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder with frame termination, forming the transmit end of the 4-state Viterbi decoding chain. It accepts one data bit per handshake, emits one 2-bit coded symbol per bit, and appends two zero tail bits per frame. The tail bits return the trellis to state 00 so the decoder's traceback can start from a known state. Its output symbol stream is the decoder's branch-metric input stream.

---
 rtl/conv_encoder_tx.sv | 148 ++++++++++++++
 tb/tb_conv_encoder_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_tx.sv
// -----------------------------------------------------------------------------
// conv_encoder_tx
//
// Rate-1/2, constraint-length-3 convolutional encoder with frame termination.
// Accepts one data bit per handshake and emits one 2-bit coded symbol per bit.
// After FRAME_LEN data bits it injects two zero tail bits, which drive the
// trellis back to state 00 so the decoder's traceback starts from a known state.
//
// Parameters:
//   FRAME_LEN  data bits per frame (>= 1)
//   G0         generator for out_sym[1], applied to {u, s[1], s[0]}
//   G1         generator for out_sym[0], applied to {u, s[1], s[0]}
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_bit is valid this cycle
//   in_ready   encoder accepts in_bit this cycle
//   in_bit     data bit u
//   out_valid  out_sym holds a valid symbol
//   out_ready  downstream consumes the symbol this cycle
//   out_sym    coded symbol {c0, c1}
//   out_last   marks the final tail symbol of a frame
// -----------------------------------------------------------------------------
module conv_encoder_tx #(
    parameter int         FRAME_LEN = 8,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last
);

    localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       s;          // {d(n-1), d(n-2)}, decoder state numbering
    logic [CNT_W-1:0] data_cnt;
    logic             tail_cnt;

    logic             slot_free;
    logic             accept;
    logic             tail_step;
    logic             step;
    logic             last_tail;
    logic             u;
    logic [2:0]       w;
    logic             c0;
    logic             c1;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DATA;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            DATA: if (accept && (data_cnt == LAST_DATA)) state_next = TAIL;
            TAIL: if (last_tail)                         state_next = DATA;
            default: state_next = DATA;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM output / handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        // The single output register can take a new symbol when it is empty
        // or when its current symbol leaves this very cycle.
        slot_free = !out_valid || out_ready;
        in_ready  = (state == DATA) && slot_free;
        accept    = in_valid && in_ready;
        tail_step = (state == TAIL) && slot_free;
        step      = accept || tail_step;
        last_tail = tail_step && tail_cnt;

        // Tail steps feed zeros regardless of in_bit.
        u  = (state == TAIL) ? 1'b0 : in_bit;
        w  = {u, s[1], s[0]};
        c0 = ^(w & G0);
        c1 = ^(w & G1);
    end

    // -------------------------------------------------------------------------
    // Encoder state, counters and output symbol register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= 2'b00;
            data_cnt  <= '0;
            tail_cnt  <= 1'b0;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                data_cnt <= (data_cnt == LAST_DATA) ? '0 : data_cnt + CNT_W'(1);
            end

            if (tail_step) begin
                tail_cnt <= ~tail_cnt;
            end

            if (step) begin
                // Two zero tail bits flush the shift register; the explicit
                // clear on the last tail just makes the frame boundary obvious.
                s         <= last_tail ? 2'b00 : {u, s[1]};
                out_valid <= 1'b1;
                out_sym   <= {c0, c1};
                out_last  <= last_tail;
            end else if (out_ready) begin
                // Symbol consumed and nothing new to load: the slot empties.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_tx
//
// Directed testbench for conv_encoder_tx with FRAME_LEN=4 and default
// generators. Frame 1,0,1,1 from state 00 encodes to 11,10,00,01 followed by
// tail symbols 01,11 (out_last on the final 11).
// -----------------------------------------------------------------------------
module tb_conv_encoder_tx;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_last;

    always #5 clk = ~clk;

    conv_encoder_tx #(
        .FRAME_LEN (FL),
        .G0        (3'b111),
        .G1        (3'b101)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;

    // Hand-computed symbols for frame 1,0,1,1 starting from s=00.
    logic [1:0] exp_sym  [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic       exp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Stream capture state filled by run_stream.
    logic [1:0] cap_sym  [$];
    logic       cap_last [$];
    int         stall_viol;
    int         rdy_stall_viol;
    int         stall_cycles;
    int         rdy_low;
    int         first_acc;
    int         first_out;

    // Drives one stream: bits[i] is the i-th data bit, vpat/rpat give in_valid
    // and out_ready per cycle for the first vlen/rlen cycles (1 afterwards).
    // Inputs change just after the falling edge; everything is observed there.
    task automatic run_stream(input int nbits, input logic [63:0] bits,
                              input logic [63:0] vpat, input int vlen,
                              input logic [63:0] rpat, input int rlen,
                              input int nsym, input int max_cyc);
        int         bi;
        logic       held;
        logic [1:0] hsym;
        logic       hlast;
        bi   = 0;
        held = 1'b0;
        hsym = 2'b00;
        hlast = 1'b0;
        cap_sym.delete();
        cap_last.delete();
        stall_viol     = 0;
        rdy_stall_viol = 0;
        stall_cycles   = 0;
        rdy_low        = 0;
        first_acc      = -1;
        first_out      = -1;
        for (int c = 0; c < max_cyc && cap_sym.size() < nsym; c++) begin
            @(negedge clk);
            if (held && (!out_valid || out_sym !== hsym || out_last !== hlast))
                stall_viol++;
            if (out_valid && first_out < 0) first_out = c;
            out_ready = (c < rlen) ? rpat[c] : 1'b1;
            if (bi < nbits && ((c < vlen) ? vpat[c] : 1'b1)) begin
                in_valid = 1'b1;
                in_bit   = bits[bi];
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
            end
            #1;
            if (!in_ready) rdy_low++;
            held = out_valid && !out_ready;
            if (held) begin
                stall_cycles++;
                hsym  = out_sym;
                hlast = out_last;
                if (in_ready) rdy_stall_viol++;
            end
            if (out_valid && out_ready) begin
                cap_sym.push_back(out_sym);
                cap_last.push_back(out_last);
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = c;
                bi++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Put a symbol in the output register, then reset over it.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_load: out_valid=%b out_sym=%b, want 1 11", out_valid, out_sym);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_sym !== 2'b00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b sym=%b last=%b, want 0 00 0",
                     out_valid, out_sym, out_last);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frames(input string name, input int nframes);
        checks++;
        if (cap_sym.size() !== 6 * nframes) begin
            errors++;
            $display("FAIL %s_count: got %0d symbols, want %0d", name, cap_sym.size(), 6 * nframes);
        end
        for (int i = 0; i < cap_sym.size() && i < 6 * nframes; i++) begin
            checks++;
            if (cap_sym[i] !== exp_sym[i % 6] || cap_last[i] !== exp_last[i % 6]) begin
                errors++;
                $display("FAIL %s_sym%0d: got sym=%b last=%b, want sym=%b last=%b",
                         name, i, cap_sym[i], cap_last[i], exp_sym[i % 6], exp_last[i % 6]);
            end
        end
    endtask

    task automatic check_idle(input string name);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle: out_valid=%b, want 0", name, out_valid);
            end
        end
    endtask

    task automatic test_basic();
        run_stream(4, 64'b1101, 64'd0, 0, 64'd0, 0, 6, 50);
        check_frames("basic", 1);
        checks++;
        if (first_out - first_acc !== 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 1", first_out - first_acc);
        end
        checks++;
        if (rdy_low !== 2) begin
            errors++;
            $display("FAIL basic_rdy_low: got %0d, want 2", rdy_low);
        end
        checks++;
        if (dut.s !== 2'b00) begin
            errors++;
            $display("FAIL basic_final_state: s=%b, want 00", dut.s);
        end
        check_idle("basic");
    endtask

    task automatic test_backpressure();
        run_stream(4, 64'b1101, 64'd0, 0, {16{4'b1001}}, 64, 6, 100);
        check_frames("bp", 1);
        checks++;
        if (stall_cycles == 0) begin
            errors++;
            $display("FAIL bp_stalls: got %0d stall cycles, want >0", stall_cycles);
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stall cycles, want 0", stall_viol);
        end
        checks++;
        if (rdy_stall_viol !== 0) begin
            errors++;
            $display("FAIL bp_in_ready: in_ready high in %0d stall cycles, want 0", rdy_stall_viol);
        end
        check_idle("bp");
    endtask

    task automatic test_back_to_back();
        run_stream(12, 64'b1101_1101_1101, 64'd0, 0, 64'd0, 0, 18, 100);
        check_frames("b2b", 3);
        checks++;
        if (rdy_low !== 6) begin
            errors++;
            $display("FAIL b2b_rdy_low: got %0d, want 6", rdy_low);
        end
        check_idle("b2b");
    endtask

    task automatic test_mid_reset();
        // Two bits of a frame, then reset: no tail may follow.
        run_stream(2, 64'b11, 64'd0, 0, 64'd0, 0, 2, 20);
        checks++;
        if (cap_sym.size() !== 2 || cap_sym[0] !== 2'b11 || cap_sym[1] !== 2'b01) begin
            errors++;
            $display("FAIL midrst_partial: got %0d symbols, want 2 (11,01)", cap_sym.size());
        end
        do_reset(2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: out_valid=%b, want 0", out_valid);
        end
        run_stream(4, 64'b1101, 64'd0, 0, 64'd0, 0, 6, 50);
        check_frames("midrst", 1);
        check_idle("midrst");
    endtask

    task automatic test_gaps();
        run_stream(4, 64'b1101, 64'b1011001, 7, 64'd0, 0, 6, 50);
        check_frames("gaps", 1);
        checks++;
        if (first_out - first_acc !== 1) begin
            errors++;
            $display("FAIL gaps_latency: got %0d cycles, want 1", first_out - first_acc);
        end
        check_idle("gaps");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        do_reset(2);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
